// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back path.
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        PRIO_LSU = 1'b0,
        PRIO_ALU = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wb_req_t;

    // x0 is architecturally zero, so a request or issue targeting it never writes.
    function automatic logic real_write(input logic vld, input logic [REG_AW-1:0] rd);
        return vld && (rd != '0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Lookups are combinational from the registered bits; a set on the same edge as a clear wins.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_vld_i,
    input  logic [REG_AW-1:0] set_rd_i,
    input  logic              clr_vld_i,
    input  logic [REG_AW-1:0] clr_rd_i,
    input  logic [REG_AW-1:0] chk_rs1_i,
    input  logic [REG_AW-1:0] chk_rs2_i,
    output logic              busy_rs1_o,
    output logic              busy_rs2_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_vld_i) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        // Applied after the clear: a fresh producer issued on the commit edge keeps the bit.
        if (real_write(set_vld_i, set_rd_i)) begin
            busy_d[set_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_rs1_o = busy_q[chk_rs1_i];
    assign busy_rs2_o = busy_q[chk_rs2_i];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and LSU (LSU-first, ALU starvation guard)
// and tracks in-flight destinations. Ready is combinational; the write port is one cycle behind the handshake.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned XLEN         = rf_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_AW-1:0]     alu_rd,
    input  logic [XLEN-1:0]       alu_wd,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [REG_AW-1:0]     lsu_rd,
    input  logic [XLEN-1:0]       lsu_wd,
    output logic                  lsu_ready,
    input  logic                  iss_valid,
    input  logic [REG_AW-1:0]     iss_rd,
    input  logic [REG_AW-1:0]     chk_rs1,
    input  logic [REG_AW-1:0]     chk_rs2,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  we3,
    output logic [REG_AW-1:0]     a3,
    output logic [XLEN-1:0]       wd3
);

    arb_state_t          state_q;
    logic [3:0]          starve_q;
    logic                we3_q;
    logic [REG_AW-1:0]   a3_q;
    logic [XLEN-1:0]     wd3_q;

    logic                grant;
    logic [REG_AW-1:0]   sel_rd;
    logic [XLEN-1:0]     sel_wd;

    assign alu_ready = alu_valid && (!lsu_valid || (state_q == PRIO_ALU));
    assign lsu_ready = lsu_valid && (!alu_valid || (state_q == PRIO_LSU));

    assign grant  = alu_ready || lsu_ready;
    assign sel_rd = alu_ready ? alu_rd : lsu_rd;
    assign sel_wd = alu_ready ? alu_wd : lsu_wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PRIO_LSU;
            starve_q <= 4'd0;
        end else if (alu_ready) begin
            starve_q <= 4'd0;
            state_q  <= PRIO_LSU;
        end else if (alu_valid) begin
            if ((starve_q + 4'd1) == 4'(STARVE_LIMIT)) begin
                state_q  <= PRIO_ALU;
                starve_q <= 4'd0;
            end else begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end

    // a3/wd3 deliberately hold on idle or x0 cycles; only we3 drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else if (real_write(grant, sel_rd)) begin
            we3_q <= 1'b1;
            a3_q  <= sel_rd;
            wd3_q <= sel_wd;
        end else begin
            we3_q <= 1'b0;
        end
    end

    assign we3 = we3_q;
    assign a3  = a3_q;
    assign wd3 = wd3_q;

    rf_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_vld_i  (iss_valid),
        .set_rd_i   (iss_rd),
        .clr_vld_i  (we3_q),
        .clr_rd_i   (a3_q),
        .chk_rs1_i  (chk_rs1),
        .chk_rs2_i  (chk_rs2),
        .busy_rs1_o (busy_rs1),
        .busy_rs2_o (busy_rs2)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file on the write port.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, lsu_valid, iss_valid;
    logic [4:0]  alu_rd, lsu_rd, iss_rd, chk_rs1, chk_rs2;
    logic [31:0] alu_wd, lsu_wd;
    logic        alu_ready, lsu_ready, busy_rs1, busy_rs2, we3;
    logic [4:0]  a3;
    logic [31:0] wd3;

    logic [31:0] rf [32];
    int n_chk  = 0;
    int n_pass = 0;

    regfile_wb_arbiter #(.STARVE_LIMIT(3), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .we3(we3), .a3(a3), .wd3(wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we3) rf[a3] <= wd3;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance to 1 ns after the next rising edge; inputs are driven there and checked 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst_n = 1'b0;
        alu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
        alu_rd = 5'd0; lsu_rd = 5'd0; iss_rd = 5'd0;
        alu_wd = 32'h0; lsu_wd = 32'h0;
        chk_rs1 = 5'd5; chk_rs2 = 5'd0;
        step(); step();
        #1;
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_a3", 32'(a3), 32'd0);
        chk("rst_wd3", wd3, 32'h0);
        chk("rst_busy", 32'(busy_rs1), 32'd0);
        chk("rst_rdy", 32'({alu_ready, lsu_ready}), 32'd0);
        rst_n = 1'b1;

        // Single ALU write to x5
        step();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
        #1;
        chk("alu_ready", 32'(alu_ready), 32'd1);
        chk("lsu_ready_idle", 32'(lsu_ready), 32'd0);
        step();
        alu_valid = 1'b0;
        #1;
        chk("wr_we3", 32'(we3), 32'd1);
        chk("wr_a3", 32'(a3), 32'd5);
        chk("wr_wd3", wd3, 32'hDEADBEEF);
        step(); #1;
        chk("idle_we3", 32'(we3), 32'd0);
        chk("idle_a3_hold", 32'(a3), 32'd5);
        chk("rf_x5", rf[5], 32'hDEADBEEF);

        // Contention: grants run LSU,LSU,LSU,ALU repeating
        alu_valid = 1'b1; alu_rd = 5'd2; alu_wd = 32'h2222;
        lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_wd = 32'h1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("cont_alu_%0d", i), 32'(alu_ready), 32'((i % 4) == 3));
            chk($sformatf("cont_lsu_%0d", i), 32'(lsu_ready), 32'((i % 4) != 3));
            step(); #1;
        end

        // Three denials move to PRIO_ALU; a lone LSU is still granted there
        step(); step(); step();
        alu_valid = 1'b0;
        #1;
        chk("lone_lsu_prio_alu", 32'(lsu_ready), 32'd1);
        step();
        alu_valid = 1'b1;
        #1;
        chk("prio_alu_alu", 32'(alu_ready), 32'd1);
        chk("prio_alu_lsu", 32'(lsu_ready), 32'd0);
        step(); #1;
        chk("back_prio_lsu", 32'(lsu_ready), 32'd1);
        alu_valid = 1'b0;

        // x0 write: handshake completes, port stays idle and holds
        lsu_rd = 5'd10; lsu_wd = 32'h0000A5A5;
        step();
        lsu_rd = 5'd0; lsu_wd = 32'h00001234; chk_rs1 = 5'd0;
        #1;
        chk("x0_lsu_ready", 32'(lsu_ready), 32'd1);
        step();
        lsu_valid = 1'b0;
        #1;
        chk("x0_we3", 32'(we3), 32'd0);
        chk("x0_a3", 32'(a3), 32'd10);
        chk("x0_wd3", wd3, 32'h0000A5A5);
        chk("x0_busy", 32'(busy_rs1), 32'd0);

        // Scoreboard set then clear on commit
        iss_valid = 1'b1; iss_rd = 5'd7; chk_rs1 = 5'd7;
        #1;
        chk("sb_before_set", 32'(busy_rs1), 32'd0);
        step();
        iss_valid = 1'b0;
        #1;
        chk("sb_set", 32'(busy_rs1), 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h77;
        step();
        alu_valid = 1'b0;
        #1;
        chk("sb_no_bypass", 32'(busy_rs1), 32'd1);
        chk("sb_we3", 32'(we3), 32'd1);
        step(); #1;
        chk("sb_clear", 32'(busy_rs1), 32'd0);
        chk("rf_x7", rf[7], 32'h77);

        // Set and clear of x9 on the same edge
        iss_valid = 1'b1; iss_rd = 5'd9; chk_rs2 = 5'd9;
        step();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'h99;
        step();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        #1;
        chk("sim_a3", 32'(a3), 32'd9);
        step();
        iss_valid = 1'b0;
        #1;
        chk("sim_busy9", 32'(busy_rs2), 32'd1);

        // Reset mid-operation: busy x3 and a pending write, no clock edge
        iss_valid = 1'b1; iss_rd = 5'd3; chk_rs1 = 5'd3;
        step();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h33;
        step();
        alu_valid = 1'b0;
        #1;
        chk("pre_rst_we3", 32'(we3), 32'd1);
        chk("pre_rst_busy3", 32'(busy_rs1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_we3", 32'(we3), 32'd0);
        chk("async_a3", 32'(a3), 32'd0);
        chk("async_busy3", 32'(busy_rs1), 32'd0);
        chk("async_busy9", 32'(busy_rs2), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard in front of the 32×32-bit register file's single write port (WE3/A3/WD3). The block shares that port between the ALU result path and the load/store unit (LSU) using valid/ready handshakes, with starvation protection for the ALU. It also tracks which destination registers have writes in flight, so the issue stage can stall on RAW hazards. It sits between the execute/memory stages and the register file.

## Interface
- `STARVE_LIMIT`, 3: consecutive cycles the ALU may be valid-and-denied before it gets priority; legal range 1..15.
- `XLEN`, 32: data width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `alu_valid` in 1 / `alu_rd` in 5 / `alu_wd` in XLEN: ALU write-back request.
- `alu_ready` out 1: ALU request accepted this cycle.
- `lsu_valid` in 1 / `lsu_rd` in 5 / `lsu_wd` in XLEN: LSU write-back request.
- `lsu_ready` out 1: LSU request accepted this cycle.
- `iss_valid` in 1 / `iss_rd` in 5: an instruction with destination `iss_rd` issues; marks `iss_rd` pending.
- `chk_rs1` in 5 / `chk_rs2` in 5: source registers to check.
- `busy_rs1` out 1 / `busy_rs2` out 1: the corresponding source has a pending write (combinational).
- `we3` out 1 / `a3` out 5 / `wd3` out XLEN: registered drive to the register-file write port.

## Operation
- **One grant per cycle.** At most one of `alu_ready` / `lsu_ready` is high in any cycle.
- **Ready is combinational** from both valids and the arbiter state. A handshake completes at a rising edge where valid and ready are both high.
- **FSM states:**
  - `PRIO_LSU` (reset state): LSU wins when both are valid.
  - `PRIO_ALU`: ALU wins when both are valid.
- **A lone valid requester is always granted**, in either state.
- **Starvation counter `starve_cnt`** (4 bits):
  - Increments when `alu_valid` is high and `alu_ready` is low.
  - Clears on any ALU grant.
  - When it would reach `STARVE_LIMIT`, the FSM moves to `PRIO_ALU` and the counter clears.
  - `PRIO_ALU` returns to `PRIO_LSU` after exactly one ALU grant.
- **Granted write:** on the edge that completes a handshake with rd≠0, the next cycle has `we3`=1 and `a3`/`wd3` equal to the granted rd/data.
- **No grant, or granted rd=0:** `we3`=0 the next cycle, and `a3`/`wd3` hold their previous values. An rd=0 request still completes its handshake; the write is discarded.
- **Scoreboard `busy[31:0]`:**
  - `busy[0]` is hard-wired to 0.
  - Set at the edge where `iss_valid`=1 and `iss_rd`≠0.
  - Cleared at the edge where `we3`=1, for index `a3`. This is the same edge the register file commits the write.
  - If set and clear hit the same index in the same edge, set wins (a new producer issued).
  - An issue to an already-busy rd leaves the bit set. WAW is not tracked; the issue stage must stall on a busy rd using `chk_rs*`.
- **`busy_rsN`** = `busy[chk_rsN]`, with no bypass from a `we3` active in the same cycle.

## Timing
- **Reset values:** `we3`=0, `a3`=0, `wd3`=0, `busy`=0, state=`PRIO_LSU`, `starve_cnt`=0. Both ready outputs are then a pure function of the valids.
- **Reset asserted mid-operation:** all in-flight writes and pending bits are discarded immediately (asynchronous reset).
- **Write latency:** handshake at edge N → `we3` high during cycle N..N+1 → register written, and busy bit cleared, at edge N+1.
- **Throughput:** one write per cycle sustained.
- **Starvation bound:** with both requesters continuously valid, the ALU is granted at least once every `STARVE_LIMIT`+1 cycles.

## Structure
- **Package `rf_pkg`:**
  - Constants: `XLEN`, `NREG`=32, `REG_AW`=5.
  - Enum `arb_state_t` {`PRIO_LSU`, `PRIO_ALU`}.
  - Struct `wb_req_t` {valid, rd, wd}.
- **Sub-module `rf_scoreboard`:** busy vector with set/clear and the two combinational lookups.
- **Top level:** contains the arbiter FSM, the starvation counter and the output registers.

## Test plan
- **Reset, then single ALU request:** assert `rst_n`=0 then release; `alu_valid`=1, rd=5, wd=0xDEADBEEF → `alu_ready`=1 the same cycle; `we3`=1, `a3`=5, `wd3`=0xDEADBEEF the next cycle; the register file reads 0xDEADBEEF at x5 afterwards.
- **Contention and starvation (`STARVE_LIMIT`=3):** both valid continuously → grants run LSU, LSU, LSU, ALU, LSU, …; the ALU is never denied for more than 3 consecutive cycles.
- **x0 write:** `lsu_valid`=1, rd=0, wd=0x1234 → `lsu_ready`=1; `we3` stays 0; `a3`/`wd3` unchanged; `busy` unchanged.
- **Scoreboard set/clear:** issue rd=7 → `busy_rs1` (`chk_rs1`=7) reads 1 from the next cycle; ALU writes rd=7 → `busy_rs1` reads 0 the cycle after `we3` (x7 committed).
- **Simultaneous set and clear:** issue rd=9 on the same edge that `we3` commits x9 → `busy[9]` remains 1.
- **Reset mid-operation:** with `busy[3]`=1 and `we3`=1 pending, assert `rst_n`=0 → `we3`=0 and `busy`=0 immediately, with no clock edge required.
